// File: rtl/alu_cond_unit.sv
// Purpose: ARM-style condition unit; holds NZCV, evaluates Cond against stored flags, gates side effects, commits ALU flags.
// Latency: one cycle; all outputs are registered, with no combinational input-to-output path.
// Backpressure: none; accepts one instruction per cycle and never stalls.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   Valid, Cond           instruction present, 4-bit condition field
//   ALUflags, FlagW       {N,Z,C,V} from the ALU; FlagW[1] updates N,Z, FlagW[0] updates C,V
//   PCS, RegW, MemW       decoder write intents; NoWrite suppresses RegWrite (compare-type ops)
//   PCSrc, RegWrite,      registered gated write enables
//   MemWrite
//   OutValid, CondEx      registered Valid and condition-passed for the instruction in the output stage
//   Flags                 stored {N,Z,C,V}
//   SquashCount           saturating count of instructions that failed their condition
module alu_cond_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUflags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             OutValid,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCount
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_true;
    logic ce;
    logic squash;

    // Evaluation always uses the stored flags, never the incoming ALUflags,
    // so an instruction sees only what earlier instructions committed.
    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    always_comb begin
        cond_true = 1'b0;
        case (Cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = !flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = !flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = !flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = !flag_v;
            4'b1000: cond_true = flag_c & !flag_z;
            4'b1001: cond_true = !flag_c | flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = !flag_z & (flag_n == flag_v);
            4'b1101: cond_true = flag_z | (flag_n != flag_v);
            4'b1110: cond_true = 1'b1;
            // 1111 is reserved and treated as "never", so it counts as squashed
            default: cond_true = 1'b0;
        endcase
    end

    assign ce     = Valid & cond_true;
    assign squash = Valid & !cond_true;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags       <= 4'b0000;
            PCSrc       <= 1'b0;
            RegWrite    <= 1'b0;
            MemWrite    <= 1'b0;
            OutValid    <= 1'b0;
            CondEx      <= 1'b0;
            SquashCount <= '0;
        end else begin
            // N,Z and C,V halves commit independently; unselected bits hold
            if (ce && FlagW[1]) begin
                Flags[3:2] <= ALUflags[3:2];
            end
            if (ce && FlagW[0]) begin
                Flags[1:0] <= ALUflags[1:0];
            end

            OutValid <= Valid;
            CondEx   <= ce;
            PCSrc    <= ce & PCS;
            RegWrite <= ce & RegW & !NoWrite;
            MemWrite <= ce & MemW;

            // Saturate at all-ones rather than wrap
            if (squash && (SquashCount != {CNT_W{1'b1}})) begin
                SquashCount <= SquashCount + CNT_W'(1);
            end
        end
    end

endmodule
